// File: rtl/tetris_pkg.sv
// Shared constants and types for the Tetris pixel renderer.
// Board geometry in cells, 12-bit 4:4:4 colour type, palette and fixed colours.
package tetris_pkg;

  localparam int unsigned BOARD_W = 10;
  localparam int unsigned BOARD_H = 20;

  typedef logic [11:0] colour_t;

  // Index 0 black; 1..7 cyan, yellow, purple, green, red, blue, orange.
  localparam colour_t PALETTE [8] = '{
    12'h000, 12'h0FF, 12'hFF0, 12'hA0F, 12'h0F0, 12'hF00, 12'h00F, 12'hF80
  };

  localparam colour_t BLACK  = 12'h000;
  localparam colour_t BORDER = 12'hFFF;
  localparam colour_t FLASH  = 12'hFFF;
  localparam colour_t GRID   = 12'h222;
  localparam colour_t GREY   = 12'h777;

  function automatic colour_t palette_lookup(input logic [2:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/tetris_pixel_renderer_if.sv
// Board RAM read bus between the renderer (master) and the board RAM (slave).
//   board_addr : row*10+col read address, 0..199
//   board_data : synchronous read data, valid one cycle after board_addr
interface tetris_pixel_renderer_if;

  logic [7:0] board_addr;
  logic [2:0] board_data;

  modport master (output board_addr, input  board_data);
  modport slave  (input  board_addr, output board_data);

endinterface

// File: rtl/tetris_piece_hit.sv
// Combinational 4-way compare of a board cell against the falling-piece cells.
//   col_i/row_i       : cell under test
//   piece_col_i/row_i : 4 packed 4-bit columns / 5-bit rows
//   valid_i           : piece present
//   hit_o             : cell is covered by the piece
module tetris_piece_hit
  import tetris_pkg::*;
(
  input  logic [3:0]  col_i,
  input  logic [4:0]  row_i,
  input  logic [15:0] piece_col_i,
  input  logic [19:0] piece_row_i,
  input  logic        valid_i,
  output logic        hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      // Off-board piece cells never match, even if they alias a real cell.
      if (valid_i &&
          piece_col_i[4*i +: 4] == col_i && piece_row_i[5*i +: 5] == row_i &&
          piece_col_i[4*i +: 4] < 4'(BOARD_W) && piece_row_i[5*i +: 5] < 5'(BOARD_H)) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tetris_pixel_renderer.sv
// Tetris pixel renderer: maps VGA pixels onto the 10x20 playfield, reads the
// board RAM, overlays piece/border/flash/grid and drives 4:4:4 RGB.
// Fixed 3-cycle latency from inputs to rgb and delayed syncs.
//   clk, rst            : pixel clock, synchronous active-high reset
//   x_pos_i, y_pos_i    : pixel position; active_i visible flag
//   hsync_i, vsync_i    : active-low syncs in; hsync_o/vsync_o delayed copies
//   ram                 : board RAM read bus (master)
//   piece_*_i, flash_rows_i, game_over_i : latched on vsync rising edge
//   vga_r_o/g_o/b_o     : colour out; frame_start_o pulses on latch
module tetris_pixel_renderer
  import tetris_pkg::*;
#(
  parameter int unsigned BOARD_X0   = 240,
  parameter int unsigned BOARD_Y0   = 80,
  parameter int unsigned CELL_LOG2  = 4,
  parameter int unsigned BORDER_W   = 4,
  parameter int unsigned BLINK_LOG2 = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [9:0]                      x_pos_i,
  input  logic [9:0]                      y_pos_i,
  input  logic                            active_i,
  input  logic                            hsync_i,
  input  logic                            vsync_i,
  tetris_pixel_renderer_if.master         ram,
  input  logic [15:0]                     piece_col_i,
  input  logic [19:0]                     piece_row_i,
  input  logic [2:0]                      piece_color_i,
  input  logic                            piece_valid_i,
  input  logic [19:0]                     flash_rows_i,
  input  logic                            game_over_i,
  output logic [3:0]                      vga_r_o,
  output logic [3:0]                      vga_g_o,
  output logic [3:0]                      vga_b_o,
  output logic                            hsync_o,
  output logic                            vsync_o,
  output logic                            frame_start_o
);

  localparam int unsigned BoardWPx = BOARD_W << CELL_LOG2;
  localparam int unsigned BoardHPx = BOARD_H << CELL_LOG2;
  localparam logic [9:0]  CellMask = 10'((1 << CELL_LOG2) - 1);

  // S1 combinational decode
  logic [9:0] bx, by, ox, oy;
  logic       in_board_d, in_border_d, off0_d;
  logic [3:0] col_d;
  logic [4:0] row_d;
  logic [7:0] addr_d;

  always_comb begin
    // Unsigned wrap makes pixels left/above the rectangle compare as outside.
    bx          = x_pos_i - 10'(BOARD_X0);
    by          = y_pos_i - 10'(BOARD_Y0);
    ox          = x_pos_i - 10'(BOARD_X0 - BORDER_W);
    oy          = y_pos_i - 10'(BOARD_Y0 - BORDER_W);
    in_board_d  = (bx < 10'(BoardWPx)) && (by < 10'(BoardHPx));
    in_border_d = (ox < 10'(BoardWPx + 2 * BORDER_W)) &&
                  (oy < 10'(BoardHPx + 2 * BORDER_W)) && !in_board_d;
    col_d       = 4'(bx >> CELL_LOG2);
    row_d       = 5'(by >> CELL_LOG2);
    off0_d      = ((bx & CellMask) == '0) || ((by & CellMask) == '0);
    addr_d      = in_board_d ? (8'(row_d) << 3) + (8'(row_d) << 1) + 8'(col_d) : 8'd0;
  end

  // Pipeline stages
  logic [3:0] s1_col_q, s2_col_q;
  logic [4:0] s1_row_q, s2_row_q;
  logic       s1_in_board_q, s2_in_board_q, s1_in_border_q, s2_in_border_q;
  logic       s1_active_q, s2_active_q, s1_off0_q, s2_off0_q;
  logic       s1_hs_q, s2_hs_q, s3_hs_q, s1_vs_q, s2_vs_q, s3_vs_q;
  logic [7:0] addr_q;
  colour_t    rgb_q, rgb_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_col_q <= '0; s1_row_q <= '0; s1_in_board_q <= 1'b0; s1_in_border_q <= 1'b0;
      s1_active_q <= 1'b0; s1_off0_q <= 1'b0; s1_hs_q <= 1'b1; s1_vs_q <= 1'b1;
      s2_col_q <= '0; s2_row_q <= '0; s2_in_board_q <= 1'b0; s2_in_border_q <= 1'b0;
      s2_active_q <= 1'b0; s2_off0_q <= 1'b0; s2_hs_q <= 1'b1; s2_vs_q <= 1'b1;
      s3_hs_q <= 1'b1; s3_vs_q <= 1'b1; addr_q <= '0; rgb_q <= BLACK;
    end else begin
      s1_col_q <= col_d; s1_row_q <= row_d; s1_in_board_q <= in_board_d;
      s1_in_border_q <= in_border_d; s1_active_q <= active_i; s1_off0_q <= off0_d;
      s1_hs_q <= hsync_i; s1_vs_q <= vsync_i; addr_q <= addr_d;
      s2_col_q <= s1_col_q; s2_row_q <= s1_row_q; s2_in_board_q <= s1_in_board_q;
      s2_in_border_q <= s1_in_border_q; s2_active_q <= s1_active_q; s2_off0_q <= s1_off0_q;
      s2_hs_q <= s1_hs_q; s2_vs_q <= s1_vs_q;
      s3_hs_q <= s2_hs_q; s3_vs_q <= s2_vs_q; rgb_q <= rgb_d;
    end
  end

  // Frame latch: snapshot piece state at the end of vsync so a frame never tears.
  logic        vs_prev_q, vs_rise, frame_start_q;
  logic [5:0]  frame_cnt_q;
  logic [15:0] pcol_q;
  logic [19:0] prow_q, flash_q;
  logic [2:0]  pcolor_q;
  logic        pvalid_q, game_over_q;

  assign vs_rise = vsync_i && !vs_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q <= 1'b1; frame_start_q <= 1'b0; frame_cnt_q <= '0;
      pcol_q <= '0; prow_q <= '0; pcolor_q <= '0; pvalid_q <= 1'b0;
      flash_q <= '0; game_over_q <= 1'b0;
    end else begin
      vs_prev_q     <= vsync_i;
      frame_start_q <= vs_rise;
      if (vs_rise) begin
        frame_cnt_q <= frame_cnt_q + 6'd1;
        pcol_q      <= piece_col_i;
        prow_q      <= piece_row_i;
        pcolor_q    <= piece_color_i;
        pvalid_q    <= piece_valid_i;
        flash_q     <= flash_rows_i;
        game_over_q <= game_over_i;
      end
    end
  end

  // S3 colour select
  logic        hit;
  logic [31:0] flash_ext;

  tetris_piece_hit u_piece_hit (
    .col_i       (s2_col_q),
    .row_i       (s2_row_q),
    .piece_col_i (pcol_q),
    .piece_row_i (prow_q),
    .valid_i     (pvalid_q),
    .hit_o       (hit)
  );

  always_comb begin
    // Widened so any 5-bit row indexes safely; only in-board rows are used.
    flash_ext = {12'd0, flash_q};
    rgb_d     = BLACK;
    if (!s2_active_q) begin
      rgb_d = BLACK;
    end else if (s2_in_border_q) begin
      rgb_d = BORDER;
    end else if (s2_in_board_q) begin
      if (flash_ext[s2_row_q] && frame_cnt_q[BLINK_LOG2]) begin
        rgb_d = FLASH;
      end else if (hit) begin
        rgb_d = palette_lookup(pcolor_q);
      end else if (ram.board_data != 3'd0) begin
        rgb_d = game_over_q ? GREY : palette_lookup(ram.board_data);
      end else if (s2_off0_q) begin
        rgb_d = GRID;
      end
    end
  end

  assign ram.board_addr = addr_q;
  assign vga_r_o        = rgb_q[11:8];
  assign vga_g_o        = rgb_q[7:4];
  assign vga_b_o        = rgb_q[3:0];
  assign hsync_o        = s3_hs_q;
  assign vsync_o        = s3_vs_q;
  assign frame_start_o  = frame_start_q;

endmodule

// File: tb/tb_tetris_pixel_renderer.sv
module tb_tetris_pixel_renderer;

  logic        clk, rst;
  logic [9:0]  x_pos, y_pos;
  logic        active, hsync_in, vsync_in;
  logic [15:0] piece_col;
  logic [19:0] piece_row, flash_rows;
  logic [2:0]  piece_color, ram_fill;
  logic        piece_valid, game_over;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync_out, vsync_out, frame_start;
  logic [11:0] rgb, got;
  int          n_cmp, n_fail, tb_frames;

  tetris_pixel_renderer_if bus ();

  tetris_pixel_renderer dut (
    .clk           (clk),
    .rst           (rst),
    .x_pos_i       (x_pos),
    .y_pos_i       (y_pos),
    .active_i      (active),
    .hsync_i       (hsync_in),
    .vsync_i       (vsync_in),
    .ram           (bus),
    .piece_col_i   (piece_col),
    .piece_row_i   (piece_row),
    .piece_color_i (piece_color),
    .piece_valid_i (piece_valid),
    .flash_rows_i  (flash_rows),
    .game_over_i   (game_over),
    .vga_r_o       (vga_r),
    .vga_g_o       (vga_g),
    .vga_b_o       (vga_b),
    .hsync_o       (hsync_out),
    .vsync_o       (vsync_out),
    .frame_start_o (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model board RAM: uniform fill for valid addresses, one-cycle read latency.
  always @(posedge clk) bus.board_data <= (bus.board_addr <= 8'd199) ? ram_fill : 3'd0;

  assign rgb = {vga_r, vga_g, vga_b};

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic act,
                     output logic [11:0] col);
    x_pos = x; y_pos = y; active = act;
    repeat (3) @(posedge clk);
    #1;
    col = rgb;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b0;
    @(posedge clk); #1;
    if (frame_start !== 1'b0) begin
      $display("FAIL fs_low got=%b exp=0", frame_start); n_fail++;
    end
    n_cmp++;
    vsync_in = 1'b1;
    @(posedge clk); #1;
    tb_frames++;
    if (frame_start !== 1'b1) begin
      $display("FAIL fs_pulse got=%b exp=1", frame_start); n_fail++;
    end
    n_cmp++;
    @(posedge clk); #1;
    if (frame_start !== 1'b0) begin
      $display("FAIL fs_once got=%b exp=0", frame_start); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_reset();
    rst = 1'b1; x_pos = 10'd256; y_pos = 10'd112; active = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b1; ram_fill = 3'd3; tb_frames = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rgb !== 12'h000) begin
        $display("FAIL rst_rgb got=%h exp=000", rgb); n_fail++;
      end
      n_cmp++;
      if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
        $display("FAIL rst_sync got=%b%b exp=11", hsync_out, vsync_out); n_fail++;
      end
      n_cmp++;
      if (bus.board_addr !== 8'd0) begin
        $display("FAIL rst_addr got=%0d exp=0", bus.board_addr); n_fail++;
      end
      n_cmp++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    if (bus.board_addr !== 8'd21) begin
      $display("FAIL rel_addr got=%0d exp=21", bus.board_addr); n_fail++;
    end
    n_cmp++;
    for (int i = 0; i < 2; i++) begin
      if (rgb !== 12'h000 || hsync_out !== 1'b1) begin
        $display("FAIL rel_early got=%h/%b exp=000/1", rgb, hsync_out); n_fail++;
      end
      n_cmp++;
      @(posedge clk); #1;
    end
    if (rgb !== 12'hA0F || hsync_out !== 1'b0) begin
      $display("FAIL rel_first got=%h/%b exp=a0f/0", rgb, hsync_out); n_fail++;
    end
    n_cmp++;
    hsync_in = 1'b1;
  endtask

  task automatic test_latency();
    ram_fill = 3'd3;
    pix(10'd300, 10'd200, 1'b1, got);
    if (bus.board_addr !== 8'd73) begin
      $display("FAIL addr_73 got=%0d exp=73", bus.board_addr); n_fail++;
    end
    n_cmp++;
    x_pos = 10'd256; y_pos = 10'd112; hsync_in = 1'b0;
    @(posedge clk); #1;
    if (bus.board_addr !== 8'd21 || hsync_out !== 1'b1) begin
      $display("FAIL lat_n1 got=%0d/%b exp=21/1", bus.board_addr, hsync_out); n_fail++;
    end
    n_cmp++;
    @(posedge clk); #1;
    if (hsync_out !== 1'b1) begin
      $display("FAIL lat_n2 got=%b exp=1", hsync_out); n_fail++;
    end
    n_cmp++;
    @(posedge clk); #1;
    if (hsync_out !== 1'b0 || rgb !== 12'hA0F) begin
      $display("FAIL lat_n3 got=%b/%h exp=0/a0f", hsync_out, rgb); n_fail++;
    end
    n_cmp++;
    hsync_in = 1'b1;
  endtask

  task automatic test_piece();
    piece_col = {4'd1, 4'd0, 4'd1, 4'd0};
    piece_row = {5'd1, 5'd1, 5'd0, 5'd0};
    piece_color = 3'd2; piece_valid = 1'b1;
    vsync_pulse();
    ram_fill = 3'd5;
    pix(10'd245, 10'd85, 1'b1, got);
    if (got !== 12'hFF0) begin
      $display("FAIL piece_00 got=%h exp=ff0", got); n_fail++;
    end
    n_cmp++;
    pix(10'd261, 10'd101, 1'b1, got);
    if (got !== 12'hFF0) begin
      $display("FAIL piece_11 got=%h exp=ff0", got); n_fail++;
    end
    n_cmp++;
    pix(10'd280, 10'd85, 1'b1, got);
    if (got !== 12'hF00) begin
      $display("FAIL board_5 got=%h exp=f00", got); n_fail++;
    end
    n_cmp++;
    // Mid-frame changes must not show until the next vsync edge.
    piece_valid = 1'b0; piece_color = 3'd7;
    pix(10'd245, 10'd85, 1'b1, got);
    if (got !== 12'hFF0) begin
      $display("FAIL no_tear got=%h exp=ff0", got); n_fail++;
    end
    n_cmp++;
    vsync_pulse();
    pix(10'd245, 10'd85, 1'b1, got);
    if (got !== 12'hF00) begin
      $display("FAIL relatch got=%h exp=f00", got); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_boundaries();
    ram_fill = 3'd0;
    pix(10'd239, 10'd80, 1'b1, got);
    if (got !== 12'hFFF) begin
      $display("FAIL b_239_80 got=%h exp=fff", got); n_fail++;
    end
    n_cmp++;
    pix(10'd240, 10'd80, 1'b1, got);
    if (got !== 12'h222) begin
      $display("FAIL b_240_80 got=%h exp=222", got); n_fail++;
    end
    n_cmp++;
    pix(10'd240, 10'd79, 1'b1, got);
    if (got !== 12'hFFF) begin
      $display("FAIL b_240_79 got=%h exp=fff", got); n_fail++;
    end
    n_cmp++;
    pix(10'd235, 10'd80, 1'b1, got);
    if (got !== 12'h000) begin
      $display("FAIL b_235_80 got=%h exp=000", got); n_fail++;
    end
    n_cmp++;
    ram_fill = 3'd1;
    pix(10'd399, 10'd399, 1'b1, got);
    if (got !== 12'h0FF) begin
      $display("FAIL b_399_399 got=%h exp=0ff", got); n_fail++;
    end
    n_cmp++;
    if (bus.board_addr !== 8'd199) begin
      $display("FAIL addr_199 got=%0d exp=199", bus.board_addr); n_fail++;
    end
    n_cmp++;
    pix(10'd400, 10'd399, 1'b1, got);
    if (got !== 12'hFFF) begin
      $display("FAIL b_400_399 got=%h exp=fff", got); n_fail++;
    end
    n_cmp++;
    if (bus.board_addr !== 8'd0) begin
      $display("FAIL addr_out got=%0d exp=0", bus.board_addr); n_fail++;
    end
    n_cmp++;
    pix(10'd404, 10'd80, 1'b1, got);
    if (got !== 12'h000) begin
      $display("FAIL b_404_80 got=%h exp=000", got); n_fail++;
    end
    n_cmp++;
    pix(10'd403, 10'd403, 1'b1, got);
    if (got !== 12'hFFF) begin
      $display("FAIL b_403_403 got=%h exp=fff", got); n_fail++;
    end
    n_cmp++;
    pix(10'd300, 10'd200, 1'b0, got);
    if (got !== 12'h000) begin
      $display("FAIL inactive got=%h exp=000", got); n_fail++;
    end
    n_cmp++;
    pix(10'd239, 10'd80, 1'b0, got);
    if (got !== 12'h000) begin
      $display("FAIL inactive_border got=%h exp=000", got); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_flash();
    logic [11:0] exp;
    int c;
    ram_fill = 3'd1; flash_rows = 20'h80000;
    vsync_pulse();
    pix(10'd250, 10'd373, 1'b1, got);
    if (got !== 12'h0FF) begin
      $display("FAIL row18 got=%h exp=0ff", got); n_fail++;
    end
    n_cmp++;
    for (int f = 0; f < 16; f++) begin
      c = tb_frames % 64;
      exp = (((c >> 3) & 1) == 1) ? 12'hFFF : 12'h0FF;
      pix(10'd250, 10'd389, 1'b1, got);
      if (got !== exp) begin
        $display("FAIL flash_f%0d got=%h exp=%h", c, got, exp); n_fail++;
      end
      n_cmp++;
      vsync_pulse();
    end
    flash_rows = 20'd0;
    vsync_pulse();
  endtask

  task automatic test_game_over();
    piece_col = {4'd1, 4'd0, 4'd1, 4'd0};
    piece_row = {5'd1, 5'd1, 5'd0, 5'd0};
    piece_color = 3'd2; piece_valid = 1'b1; game_over = 1'b1;
    vsync_pulse();
    ram_fill = 3'd4;
    pix(10'd245, 10'd85, 1'b1, got);
    if (got !== 12'hFF0) begin
      $display("FAIL go_piece got=%h exp=ff0", got); n_fail++;
    end
    n_cmp++;
    pix(10'd280, 10'd85, 1'b1, got);
    if (got !== 12'h777) begin
      $display("FAIL go_grey got=%h exp=777", got); n_fail++;
    end
    n_cmp++;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    piece_col = '0; piece_row = '0; piece_color = '0; piece_valid = 1'b0;
    flash_rows = '0; game_over = 1'b0;
    test_reset();
    test_latency();
    test_piece();
    test_boundaries();
    test_flash();
    test_game_over();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
